vga_scanout_ctrl: RTL and testbench

- Parametrised VGA scan-out engine, successor to the fixed-timing two-port vga_controller.
- Generates programmable-by-parameter sync timing and a linear pixel read stream into one of NUM_BUFFERS framebuffers over a fixed-latency read port.
- Delivers the pixel data, aligned with delayed syncs and data-enable, to the DAC/pin interface.
- Sits between the AXI framebuffer writer (which signals readiness and requests buffer flips) and the VGA pins.

---
 rtl/vga_scanout_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_vga_scanout_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout_ctrl.sv
// vga_scanout_ctrl: parametrised VGA scan-out engine.
//   Runs h/v timing counters, issues a linear pixel read stream into the
//   currently displayed framebuffer over a fixed-latency read port, and
//   presents the returned pixels aligned with delayed hsync/vsync/de.
//   Buffer flips requested by the framebuffer writer are applied only on
//   frame boundaries.
// Ports:
//   vga_clk, rst             pixel clock, async active-high reset
//   axi_vga_ready            writer has the first frame ready (starts scan-out)
//   vga_ready                scan-out running
//   swap_req / swap_ack      flip request / one-cycle pulse when the flip lands
//   disp_buf                 buffer currently being scanned
//   rd_en/rd_buf/rd_addr     pixel read request
//   rd_data                  read data, valid RD_LATENCY cycles after rd_en
//   frame_start,hsync,vsync,de,rgb_out   pin-side video outputs
module vga_scanout_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int PIXEL_WIDTH = 15,
  parameter int NUM_BUFFERS = 2,
  parameter int RD_LATENCY  = 1,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  localparam int BUF_W      = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
  input  logic                   vga_clk,
  input  logic                   rst,
  input  logic                   axi_vga_ready,
  output logic                   vga_ready,
  input  logic                   swap_req,
  output logic                   swap_ack,
  output logic [BUF_W-1:0]       disp_buf,
  output logic                   rd_en,
  output logic [BUF_W-1:0]       rd_buf,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   frame_start,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   de,
  output logic [PIXEL_WIDTH-1:0] rgb_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // One extra count of headroom so every timing bound (up to H_TOTAL) fits.
  localparam int HC_W    = $clog2(H_TOTAL + 1);
  localparam int VC_W    = $clog2(V_TOTAL + 1);
  // Syncs/de/frame_start trail rd_en by the read latency plus the rgb register.
  localparam int PIPE    = RD_LATENCY + 1;

  // Bit positions of the active-high timing flags carried down the pipe.
  localparam int B_HS = 0;
  localparam int B_VS = 1;
  localparam int B_DE = 2;
  localparam int B_FS = 3;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t state_q, state_d;
  logic   run;

  logic [HC_W-1:0]        h_cnt_q, h_cnt_d;
  logic [VC_W-1:0]        v_cnt_q, v_cnt_d;
  logic [ADDR_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
  logic                   pend_q, pend_d;
  logic [BUF_W-1:0]       disp_buf_q, disp_buf_d;
  logic                   swap_ack_q, swap_ack_d;
  logic                   rd_en_q, rd_en_d;
  logic [BUF_W-1:0]       rd_buf_q, rd_buf_d;
  logic [ADDR_WIDTH-1:0]  rd_addr_q, rd_addr_d;
  logic [3:0]             s1_q, s1_d;
  logic [PIPE-1:0][3:0]   dly_q, dly_d;
  logic [PIXEL_WIDTH-1:0] rgb_q, rgb_d;

  logic h_last, v_last, frame_end, active_c, swap_c;
  logic [BUF_W-1:0] disp_nxt;

  // Only the low PIXEL_WIDTH bits carry a pixel.
  logic unused_rd_data;
  assign unused_rd_data = ^rd_data;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == S_IDLE && axi_vga_ready) state_d = S_RUN;
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    run       = (state_q == S_RUN);
    vga_ready = run;
  end

  // ---------------- counter stage ----------------
  always_comb begin
    h_last    = (h_cnt_q == HC_W'(H_TOTAL - 1));
    v_last    = (v_cnt_q == VC_W'(V_TOTAL - 1));
    frame_end = run && h_last && v_last;
    active_c  = run && (h_cnt_q < HC_W'(H_ACTIVE)) && (v_cnt_q < VC_W'(V_ACTIVE));

    h_cnt_d   = h_cnt_q;
    v_cnt_d   = v_cnt_q;
    pix_cnt_d = pix_cnt_q;
    if (!run) begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      pix_cnt_d = '0;
    end else begin
      if (h_last) begin
        h_cnt_d = '0;
        v_cnt_d = v_last ? '0 : v_cnt_q + VC_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + HC_W'(1);
      end
      // Linear pixel index: restart each frame, step once per active pixel.
      if (frame_end)     pix_cnt_d = '0;
      else if (active_c) pix_cnt_d = pix_cnt_q + ADDR_WIDTH'(1);
    end
  end

  // ---------------- buffer flip ----------------
  always_comb begin
    disp_nxt   = (disp_buf_q == BUF_W'(NUM_BUFFERS - 1)) ? '0 : disp_buf_q + BUF_W'(1);
    // A request arriving on the boundary cycle itself still counts here.
    swap_c     = frame_end && (pend_q || swap_req);
    pend_d     = swap_c ? 1'b0 : (pend_q || swap_req);
    disp_buf_d = swap_c ? disp_nxt : disp_buf_q;
    swap_ack_d = swap_c;
  end

  // ---------------- read stage + alignment pipe ----------------
  always_comb begin
    rd_en_d   = active_c;
    rd_addr_d = active_c ? pix_cnt_q : rd_addr_q;
    // disp_buf only moves on the frame-end edge, so rd_buf is frame-stable.
    rd_buf_d  = disp_buf_q;

    s1_d       = '0;
    s1_d[B_DE] = active_c;
    s1_d[B_HS] = run && (h_cnt_q >= HC_W'(H_ACTIVE + H_FP))
                     && (h_cnt_q <  HC_W'(H_ACTIVE + H_FP + H_SYNC));
    s1_d[B_VS] = run && (v_cnt_q >= VC_W'(V_ACTIVE + V_FP))
                     && (v_cnt_q <  VC_W'(V_ACTIVE + V_FP + V_SYNC));
    s1_d[B_FS] = run && (h_cnt_q == '0) && (v_cnt_q == '0);

    dly_d    = dly_q;
    dly_d[0] = s1_q;
    for (int i = 1; i < PIPE; i++) dly_d[i] = dly_q[i-1];

    // Capture the pixel on the same edge its de reaches the output stage.
    rgb_d = dly_q[PIPE-2][B_DE] ? rd_data[PIXEL_WIDTH-1:0] : '0;
  end

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      pix_cnt_q  <= '0;
      pend_q     <= 1'b0;
      disp_buf_q <= '0;
      swap_ack_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_buf_q   <= '0;
      rd_addr_q  <= '0;
      s1_q       <= '0;
      dly_q      <= '0;
      rgb_q      <= '0;
    end else begin
      h_cnt_q    <= h_cnt_d;
      v_cnt_q    <= v_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      pend_q     <= pend_d;
      disp_buf_q <= disp_buf_d;
      swap_ack_q <= swap_ack_d;
      rd_en_q    <= rd_en_d;
      rd_buf_q   <= rd_buf_d;
      rd_addr_q  <= rd_addr_d;
      s1_q       <= s1_d;
      dly_q      <= dly_d;
      rgb_q      <= rgb_d;
    end
  end

  // ---------------- outputs ----------------
  assign swap_ack    = swap_ack_q;
  assign disp_buf    = disp_buf_q;
  assign rd_en       = rd_en_q;
  assign rd_buf      = rd_buf_q;
  assign rd_addr     = rd_addr_q;
  assign de          = dly_q[PIPE-1][B_DE];
  assign frame_start = dly_q[PIPE-1][B_FS];
  // Flags are active-high internally; cleared pipe gives the inactive level.
  assign hsync       = (HSYNC_POL != 0) ? dly_q[PIPE-1][B_HS] : ~dly_q[PIPE-1][B_HS];
  assign vsync       = (VSYNC_POL != 0) ? dly_q[PIPE-1][B_VS] : ~dly_q[PIPE-1][B_VS];
  assign rgb_out     = rgb_q;

endmodule

// File: tb/tb_vga_scanout_ctrl.sv
// Bench for vga_scanout_ctrl: small timing (8x6 = 48-cycle frame), three
// buffers, two instances with read latency 1 and 3 sharing control inputs.
module tb_vga_scanout_ctrl;

  localparam int HT = 8;
  localparam int VT = 6;
  localparam int FR = HT * VT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic axi_vga_ready = 1'b0;
  logic swap_req = 1'b0;

  logic        vr1, ack1, en1, fs1, hs1, vs1, de1;
  logic [1:0]  dbuf1, rbuf1;
  logic [31:0] addr1, rdat1;
  logic [14:0] rgb1;
  logic        vr3, ack3, en3, fs3, hs3, vs3, de3;
  logic [1:0]  dbuf3, rbuf3;
  logic [31:0] addr3, rdat3;
  logic [14:0] rgb3;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 0;
  int ack_cnt = 0;

  always #5 clk = ~clk;

  vga_scanout_ctrl #(.NUM_BUFFERS(3), .RD_LATENCY(1),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut1 (
    .vga_clk(clk), .rst(rst), .axi_vga_ready(axi_vga_ready), .vga_ready(vr1),
    .swap_req(swap_req), .swap_ack(ack1), .disp_buf(dbuf1), .rd_en(en1),
    .rd_buf(rbuf1), .rd_addr(addr1), .rd_data(rdat1), .frame_start(fs1),
    .hsync(hs1), .vsync(vs1), .de(de1), .rgb_out(rgb1));

  vga_scanout_ctrl #(.NUM_BUFFERS(3), .RD_LATENCY(3),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)) dut3 (
    .vga_clk(clk), .rst(rst), .axi_vga_ready(axi_vga_ready), .vga_ready(vr3),
    .swap_req(swap_req), .swap_ack(ack3), .disp_buf(dbuf3), .rd_en(en3),
    .rd_buf(rbuf3), .rd_addr(addr3), .rd_data(rdat3), .frame_start(fs3),
    .hsync(hs3), .vsync(vs3), .de(de3), .rgb_out(rgb3));

  // Framebuffer memories: return 0x10000+addr RD_LATENCY cycles after rd_en,
  // garbage otherwise so rgb gating is exercised.
  logic        m1_v = 1'b0;
  logic [31:0] m1_a = '0;
  logic        m3_v [3] = '{default: 1'b0};
  logic [31:0] m3_a [3] = '{default: '0};
  always @(posedge clk) begin
    m1_v <= en1;  m1_a <= addr1;
    m3_v[0] <= en3; m3_a[0] <= addr3;
    m3_v[1] <= m3_v[0]; m3_a[1] <= m3_a[0];
    m3_v[2] <= m3_v[1]; m3_a[2] <= m3_a[1];
  end
  assign rdat1 = m1_v    ? 32'h10000 + m1_a    : 32'hDEADBEEF;
  assign rdat3 = m3_v[2] ? 32'h10000 + m3_a[2] : 32'hDEADBEEF;

  // ---------------- reference model ----------------
  // krun = clock edges since the edge that started scan-out (-1 = idle).
  // The counter stage shows frame position krun%FR; the read stage shows
  // the position one edge older; the pin outputs a further L+1 edges older.
  int krun = -1;
  int m_disp = 0;
  int m_rdbuf = 0;
  bit m_pend = 0;
  bit m_ack = 0;

  always @(posedge clk or posedge rst) begin
    bit flip;
    if (rst) begin
      krun = -1; m_disp = 0; m_rdbuf = 0; m_pend = 0; m_ack = 0;
    end else begin
      m_rdbuf = m_disp;
      if (krun >= 0) krun++;
      else if (axi_vga_ready) krun = 0;
      flip   = (krun > 0) && (krun % FR == 0) && (m_pend || swap_req);
      m_pend = flip ? 1'b0 : (m_pend || swap_req);
      m_ack  = flip;
      if (flip) m_disp = (m_disp + 1) % 3;
    end
  end

  function automatic bit is_act(input int p);
    return ((p % HT) < 4) && ((p / HT) < 3);
  endfunction

  function automatic int pix_of(input int p);
    return (p / HT) * 4 + (p % HT);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input string tg, input int L, input logic vr, input logic en,
                         input logic [1:0] rb, input logic [31:0] ad, input logic [1:0] db,
                         input logic ak, input logic fs, input logic hs, input logic vs,
                         input logic dv, input logic [14:0] rgb);
    int  j, jd, p, h, v;
    bit  val, e_de;
    j   = krun - 1;
    jd  = krun - L - 2;
    chk({tg, ".vga_ready"}, vr, krun >= 0);
    chk({tg, ".disp_buf"}, db, m_disp);
    chk({tg, ".swap_ack"}, ak, m_ack);
    if (krun >= 0 && j >= 0 && is_act(j % FR)) begin
      chk({tg, ".rd_en"}, en, 1);
      chk({tg, ".rd_addr"}, ad, pix_of(j % FR));
      chk({tg, ".rd_buf"}, rb, m_rdbuf);
    end else begin
      chk({tg, ".rd_en"}, en, 0);
    end
    val  = (krun >= 0) && (jd >= 0);
    p    = val ? jd % FR : 0;
    h    = p % HT;
    v    = p / HT;
    e_de = val && is_act(p);
    chk({tg, ".de"}, dv, e_de);
    chk({tg, ".hsync"}, hs, !(val && h >= 5 && h < 7));
    chk({tg, ".vsync"}, vs, !(val && v == 4));
    chk({tg, ".frame_start"}, fs, val && p == 0);
    chk({tg, ".rgb_out"}, rgb, e_de ? pix_of(p) : 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_dut("L1", 1, vr1, en1, rbuf1, addr1, dbuf1, ack1, fs1, hs1, vs1, de1, rgb1);
      cmp_dut("L3", 3, vr3, en3, rbuf3, addr3, dbuf3, ack3, fs3, hs3, vs3, de3, rgb3);
      if (ack1 === 1'b1) ack_cnt++;
    end
  end

  // Advance to the posedge where the counter stage sits at frame position tgt.
  task automatic wait_pos(input int tgt);
    bit ok = 0;
    for (int i = 0; i < 3 * FR; i++) begin
      @(posedge clk); #1;
      if (krun >= 0 && krun % FR == tgt) begin ok = 1; break; end
    end
    chk("wait_pos_reached", ok, 1);
  endtask

  task automatic pulse_swap();
    swap_req = 1'b1;
    @(posedge clk); #1;
    swap_req = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic        w_en [6];
    logic [31:0] w_ad [6];
    logic        w_de [6];
    logic [14:0] w_rgb [6];
    int waited, n_de, n_hs, n_vs, fs_at;

    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle: 20 cycles with no start (model checks no reads, syncs inactive).
    repeat (20) @(posedge clk);
    #1;
    chk("idle.vga_ready", vr1, 0);
    chk("idle.hsync", hs1, 1);

    // Start: first rd_en on the third falling edge after raising the request.
    axi_vga_ready = 1'b1;
    waited = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (en1 === 1'b1) begin waited = i; break; end
    end
    chk("first_rd_en_delay", waited, 3);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      w_en[i] = en1; w_ad[i] = addr1; w_de[i] = de1; w_rgb[i] = rgb1;
    end
    for (int i = 0; i < 4; i++) begin
      chk("start.rd_en", w_en[i], 1);
      chk("start.rd_addr", w_ad[i], i);
    end
    chk("start.rd_en_off", w_en[4], 0);
    chk("start.de_lag1", w_de[1], 0);
    chk("start.de_lag2", w_de[2], 1);
    chk("start.rgb_px1", w_rgb[3], 15'd1);

    // One full frame of output statistics, starting at a frame_start.
    waited = 0;
    for (int i = 1; i <= 2 * FR; i++) begin
      @(negedge clk);
      if (fs1 === 1'b1) begin waited = i; break; end
    end
    chk("frame_start_seen", waited != 0, 1);
    n_de = 0; n_hs = 0; n_vs = 0; fs_at = 0;
    for (int i = 1; i <= FR; i++) begin
      @(negedge clk);
      if (de1 === 1'b1) n_de++;
      if (hs1 === 1'b0) n_hs++;
      if (vs1 === 1'b0) n_vs++;
      if (fs1 === 1'b1 && fs_at == 0) fs_at = i;
    end
    chk("pixels_per_frame", n_de, 12);
    chk("hsync_low_cycles", n_hs, 12);
    chk("vsync_low_cycles", n_vs, 8);
    chk("frame_period", fs_at, 48);

    // Mid-frame request: no flip until the frame ends, then exactly one.
    @(posedge clk); #1;
    pulse_swap();
    chk("swap_mid.held", dbuf1, 0);
    repeat (60) @(posedge clk);
    #1;
    chk("swap_mid.disp", dbuf1, 1);
    chk("swap_mid.acks", ack_cnt, 1);

    // Request on the boundary cycle itself: honoured at that boundary.
    wait_pos(FR - 1);
    pulse_swap();
    chk("swap_edge.disp1", dbuf1, 2);
    chk("swap_edge.disp3", dbuf3, 2);
    chk("swap_edge.ack", ack1, 1);

    // Two requests in one frame collapse into a single flip (wraps to 0).
    wait_pos(5);
    pulse_swap();
    wait_pos(20);
    pulse_swap();
    wait_pos(1);
    chk("swap_dbl.disp", dbuf1, 0);
    chk("swap_dbl.acks", ack_cnt, 3);
    repeat (FR) @(posedge clk);
    #1;
    chk("swap_dbl.no_extra", ack_cnt, 3);

    // Reset in the middle of a line: outputs drop without waiting for a clock.
    axi_vga_ready = 1'b0;
    wait_pos(10);
    rst = 1'b1;
    #1;
    chk("rst.vga_ready", vr1, 0);
    chk("rst.rd_en", en1, 0);
    chk("rst.rd_addr", addr1, 0);
    chk("rst.de", de1, 0);
    chk("rst.hsync", hs1, 1);
    chk("rst.vsync", vs1, 1);
    chk("rst.rgb", rgb1, 0);
    chk("rst.disp3", dbuf3, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("restart.needs_ready", vr1, 0);
    axi_vga_ready = 1'b1;
    repeat (2 * FR) @(posedge clk);
    #1;
    chk("restart.vga_ready", vr3, 1);
    chk("restart.disp", dbuf1, 0);

    @(negedge clk);
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog: the directed sequence is far shorter than this.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
